// File: rtl/ica_pkg.sv
`default_nettype none
// ica_pkg: shared FSM encoding and sizing helpers for the FastICA centering stage.
// Rev 1.0
package ica_pkg;

  typedef enum logic [2:0] {
    CENT_IDLE  = 3'd0,
    CENT_ACCUM = 3'd1,
    CENT_MEAN  = 3'd2,
    CENT_SUB   = 3'd3,
    CENT_DONE  = 3'd4
  } cent_state_e;

  function automatic int cent_log2(input int samples);
    return $clog2(samples);
  endfunction

  // Summing 2^k samples grows the magnitude by k bits, so the sum never overflows.
  function automatic int cent_acc_width(input int data_width, input int samples);
    return data_width + $clog2(samples);
  endfunction

endpackage
`default_nettype wire

// File: rtl/center_sat_sub.sv
`default_nettype none
// center_sat_sub: combinational a-b at one extra bit, saturated back to DATA_WIDTH.
// Rev 1.0
module center_sat_sub #(
  parameter int DATA_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] y_o
);

  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [DATA_WIDTH:0] diff;

  assign diff = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};

  // Top two bits disagree only when the result left the DATA_WIDTH range.
  assign y_o = (diff[DATA_WIDTH] != diff[DATA_WIDTH-1])
             ? (diff[DATA_WIDTH] ? SAT_MIN : SAT_MAX)
             : diff[DATA_WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/centering.sv
`default_nettype none
// centering: captures a DIM x SAMPLES block, computes per-row means and subtracts them.
// Rev 1.0
module centering
  import ica_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DIM        = 3,
  parameter int SAMPLES    = 4
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  en,
  input  logic [0:DATA_WIDTH*DIM*SAMPLES-1]     X_in,
  output logic [0:DATA_WIDTH*DIM*SAMPLES-1]     X_cent,
  output logic [DATA_WIDTH*DIM-1:0]             mean_vec,
  output logic                                  cent_opvld
);

  localparam int N            = DATA_WIDTH * DIM * SAMPLES;
  localparam int LOG2_SAMPLES = cent_log2(SAMPLES);
  localparam int ACC_W        = cent_acc_width(DATA_WIDTH, SAMPLES);

  cent_state_e                     state_q, state_d;
  logic [LOG2_SAMPLES-1:0]         s_count_q, s_count_d;
  logic [0:N-1]                    buf_q, buf_d;
  logic [DIM-1:0][ACC_W-1:0]       acc_q, acc_d;
  logic [0:N-1]                    x_cent_d;
  logic [DATA_WIDTH*DIM-1:0]       mean_vec_d;
  logic                            cent_opvld_d;

  logic [DIM-1:0][DATA_WIDTH-1:0]  row_sample;
  logic [DIM-1:0][DATA_WIDTH-1:0]  row_sat;
  logic                            last_sample;

  assign last_sample = (s_count_q == LOG2_SAMPLES'(SAMPLES - 1));

  for (genvar d = 0; d < DIM; d++) begin : g_row
    assign row_sample[d] = buf_q[(d*SAMPLES + int'(s_count_q))*DATA_WIDTH +: DATA_WIDTH];

    center_sat_sub #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_sat_sub (
      .a   (row_sample[d]),
      .b   (mean_vec[d*DATA_WIDTH +: DATA_WIDTH]),
      .y_o (row_sat[d])
    );
  end

  always_comb begin
    state_d      = state_q;
    s_count_d    = s_count_q;
    buf_d        = buf_q;
    acc_d        = acc_q;
    x_cent_d     = X_cent;
    mean_vec_d   = mean_vec;
    cent_opvld_d = cent_opvld;

    if (en) begin
      case (state_q)
        CENT_IDLE: begin
          buf_d        = X_in;
          acc_d        = '0;
          s_count_d    = '0;
          cent_opvld_d = 1'b0;
          state_d      = CENT_ACCUM;
        end
        CENT_ACCUM: begin
          for (int d = 0; d < DIM; d++) begin
            acc_d[d] = acc_q[d] + {{LOG2_SAMPLES{row_sample[d][DATA_WIDTH-1]}}, row_sample[d]};
          end
          s_count_d = last_sample ? '0 : s_count_q + LOG2_SAMPLES'(1);
          if (last_sample) state_d = CENT_MEAN;
        end
        CENT_MEAN: begin
          // Taking the top DATA_WIDTH bits is the arithmetic shift by LOG2_SAMPLES.
          for (int d = 0; d < DIM; d++) begin
            mean_vec_d[d*DATA_WIDTH +: DATA_WIDTH] = acc_q[d][LOG2_SAMPLES +: DATA_WIDTH];
          end
          state_d = CENT_SUB;
        end
        CENT_SUB: begin
          for (int d = 0; d < DIM; d++) begin
            x_cent_d[(d*SAMPLES + int'(s_count_q))*DATA_WIDTH +: DATA_WIDTH] = row_sat[d];
          end
          s_count_d = last_sample ? '0 : s_count_q + LOG2_SAMPLES'(1);
          if (last_sample) state_d = CENT_DONE;
        end
        CENT_DONE: begin
          cent_opvld_d = 1'b1;
          state_d      = CENT_IDLE;
        end
        default: state_d = CENT_IDLE;
      endcase
    end else if (state_q == CENT_IDLE) begin
      cent_opvld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= CENT_IDLE;
      s_count_q  <= '0;
      buf_q      <= '0;
      acc_q      <= '0;
      X_cent     <= '0;
      mean_vec   <= '0;
      cent_opvld <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_count_q  <= s_count_d;
      buf_q      <= buf_d;
      acc_q      <= acc_d;
      X_cent     <= x_cent_d;
      mean_vec   <= mean_vec_d;
      cent_opvld <= cent_opvld_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_centering.sv
`default_nettype none
// tb_centering: directed and randomized self-checking bench for the centering stage.
// Rev 1.0
module tb_centering;

  localparam int W = 16;
  localparam int D = 3;
  localparam int S = 4;
  localparam int N = W * D * S;

  logic           clk = 1'b0;
  logic           rstn;
  logic           en;
  logic [0:N-1]   X_in;
  logic [0:N-1]   X_cent;
  logic [W*D-1:0] mean_vec;
  logic           cent_opvld;

  int checks = 0;
  int errors = 0;
  int blk[D][S];
  int cap[D][S];
  int blk_a[D][S];
  int blk_b[D][S];

  centering #(
    .DATA_WIDTH (W),
    .DIM        (D),
    .SAMPLES    (S)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .X_in       (X_in),
    .X_cent     (X_cent),
    .mean_vec   (mean_vec),
    .cent_opvld (cent_opvld)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Mean rounded toward minus infinity, via a non-negative remainder.
  function automatic int floor_mean(input int sum);
    int r;
    r = ((sum % S) + S) % S;
    return (sum - r) / S;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load();
    for (int d = 0; d < D; d++)
      for (int s = 0; s < S; s++) begin
        X_in[(d*S+s)*W +: W] = blk[d][s][W-1:0];
        cap[d][s] = blk[d][s];
      end
  endtask

  task automatic rand_blk();
    int r;
    for (int d = 0; d < D; d++)
      for (int s = 0; s < S; s++) begin
        r = int'($urandom_range(0, 9));
        if (r == 0)      blk[d][s] = 32767;
        else if (r == 1) blk[d][s] = -32768;
        else             blk[d][s] = int'($urandom_range(0, 65535)) - 32768;
      end
  endtask

  task automatic set_basic();
    blk[0] = '{1, 2, 3, 6};
    blk[1] = '{5, 5, 5, 5};
    blk[2] = '{-1, -2, -3, -4};
  endtask

  task automatic chk_out(input string tag);
    int sum, m;
    logic signed [W-1:0] v;
    for (int d = 0; d < D; d++) begin
      sum = 0;
      for (int s = 0; s < S; s++) sum += cap[d][s];
      m = floor_mean(sum);
      v = mean_vec[d*W +: W];
      chk_int($sformatf("%s mean[%0d]", tag, d), int'(v), m);
      for (int s = 0; s < S; s++) begin
        v = X_cent[(d*S+s)*W +: W];
        chk_int($sformatf("%s xcent[%0d][%0d]", tag, d, s), int'(v), clamp16(cap[d][s] - m));
      end
    end
  endtask

  // Starts from IDLE; the first edge captures X_in. sa/ss are stall cycles in ACCUM/SUB.
  task automatic run(input string tag, input int sa, input int ss, input bit poke);
    int cyc;
    en  = 1'b1;
    cyc = 0;
    do begin
      step();
      cyc++;
      if (poke && cyc == 1)
        for (int i = 0; i < D*S; i++) X_in[i*W +: W] = 16'h7FFF;
      en = !((cyc >= 2 && cyc < 2 + sa) || (cyc >= 7 + sa && cyc < 7 + sa + ss));
    end while (!cent_opvld && cyc < 100);
    chk_int({tag, " latency"}, cyc, 11 + sa + ss);
    chk_out(tag);
  endtask

  initial begin
    rstn = 1'b0;
    en   = 1'b0;
    X_in = '0;
    repeat (3) step();
    chk_vec("reset xcent", X_cent, '0);
    chk_int("reset mean", int'(mean_vec), 0);
    chk_int("reset opvld", int'(cent_opvld), 0);
    rstn = 1'b1;
    step();

    set_basic();
    load();
    run("basic", 0, 0, 1'b0);
    en = 1'b0;
    step();
    chk_int("basic pulse clear", int'(cent_opvld), 0);

    rand_blk();
    blk[0] = '{32767, 32767, -32768, -32768};
    load();
    run("sat", 0, 0, 1'b0);
    en = 1'b0;
    step();

    set_basic();
    load();
    run("stall", 5, 3, 1'b0);
    en = 1'b0;
    step();

    rand_blk();
    load();
    run("iso", 0, 0, 1'b1);
    en = 1'b0;
    step();

    rand_blk();
    load();
    en = 1'b1;
    repeat (8) step();
    rstn = 1'b0;
    #1;
    chk_vec("midreset xcent", X_cent, '0);
    chk_int("midreset mean", int'(mean_vec), 0);
    chk_int("midreset opvld", int'(cent_opvld), 0);
    repeat (2) begin
      step();
      chk_int("midreset opvld hold", int'(cent_opvld), 0);
    end
    rstn = 1'b1;
    en   = 1'b0;
    step();
    chk_int("after reset opvld", int'(cent_opvld), 0);
    set_basic();
    load();
    run("after reset", 0, 0, 1'b0);

    rand_blk();
    blk_a = blk;
    rand_blk();
    blk_b = blk;
    for (int i = 0; i < 6; i++) begin
      blk = (i % 2 == 0) ? blk_a : blk_b;
      load();
      run($sformatf("b2b%0d", i), 0, 0, 1'b0);
    end
    en = 1'b0;
    step();
    chk_int("b2b pulse clear", int'(cent_opvld), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
